uart_tx_controller: RTL and testbench
=====================================

// Module: uart_tx_controller
// PURPOSE
//   Memory-mapped UART transmitter; the TX-side counterpart of the RX-only uart controller on the CPU bus.
//   CPU stores bytes into a FIFO; an 8N1 serializer (8E1 with parity option) drives uart_tx at a fixed baud.
//   Sits beside the RX controller in the SoC top, clocked by cpu_clk, selected by bus-decoded ren/wen.
// PARAMETERS
//   CLK_HZ        27000000  input clock frequency in Hz
//   BAUD          115200    line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, 234 at defaults)
//   FIFO_DEPTH_LG 4         log2 of FIFO depth (16 entries)
// PORTS
//   clk          in   1   single clock for all logic
//   reset        in   1   asynchronous, active-low reset
//   ren          in   1   bus read strobe (decoded by bus)
//   wen          in   1   bus write strobe (decoded by bus)
//   address      in   2   register select, byte offset [1:0] of data_addr
//   data_in      in   32  CPU store data
//   byte_select  in   4   store byte enables; lane 0 must be set for a TX push
//   data_out     out  32  read data, combinational from address
//   uart_tx      out  1   serial line, idle high
//   irq_empty    out  1   high while FIFO empty and serializer idle
// BEHAVIOUR
//   Register map: addr 0 W = push data_in[7:0] (only if byte_select[0]); addr 0 R = 0.
//     addr 1 R = {27'b0, overflow, busy, full, empty, 1'b0}; addr 1 W with data_in[4]=1 clears overflow.
//     addr 2/3: reads 0, writes ignored.
//   Reset (reset=0, async): uart_tx=1, FIFO empty (rd/wr ptr=0, count=0), overflow=0, FSM=IDLE,
//     baud counter=0, bit index=0; irq_empty=1. Deassertion takes effect at next clk edge.
//   FIFO: count width FIFO_DEPTH_LG+1; full when count==2**FIFO_DEPTH_LG; pointers wrap modulo depth.
//     Push while full: data dropped, overflow<=1 (sticky). Push while empty and FSM popping same cycle
//     cannot occur (pop requires !empty). Simultaneous push+pop: count unchanged, both pointers advance.
//   FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
//     IDLE: if !empty, pop head into shift reg, state<=START, baud counter<=0.
//     START: uart_tx=0 for CLKS_PER_BIT cycles.
//     DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; bit index 0..7.
//     STOP: uart_tx=1 for CLKS_PER_BIT cycles; at end, if !empty pop and go directly to START
//       (back-to-back frames, no idle gap), else IDLE.
//   uart_tx is a registered output (no glitches); frame length 10*CLKS_PER_BIT cycles (11 with parity).
//   Latency: write at edge N -> FIFO non-empty after N -> pop at N+1 -> uart_tx falls after edge N+2.
//   busy = (FSM != IDLE). empty/full reflect FIFO only. irq_empty = empty & !busy, registered.
//   Writes during an active frame never disturb the shift register or the baud counter.
//   ren has no side effects (status reads are non-destructive).
// CONFIGURATION
//   UART_TX_PARITY_EN defined: PARITY state inserted after DATA, sends even parity (XOR of 8 data bits),
//     frame = 11*CLKS_PER_BIT; status bit 5 reads 1 (parity present).
//   Not defined: 8N1 only, PARITY state absent from the FSM encoding, status bit 5 reads 0.
// TESTING
//   Write 0x55 to addr 0 after reset -> uart_tx low 2 clks later; sample mid-bit every 234 clks:
//     0,1,0,1,0,1,0,1,0,1 (start,data LSB first,stop); irq_empty returns 1 after 2340 clks.
//   Write 0x41,0x42,0x43 back-to-back -> three contiguous frames, no idle cycles between stop and start;
//     status reads busy=1, empty=0 after first write.
//   17 writes while TX blocked by first frame -> full=1 at count 16, 17th byte dropped, overflow=1;
//     16 frames emitted; write addr 1 data 0x10 -> overflow=0.
//   Write with byte_select=4'b0010 to addr 0 -> no push, empty stays 1, uart_tx stays 1.
//   Assert reset mid-DATA (bit 3 of 0xA5) -> uart_tx=1 immediately (async), status reads 0x02 (empty only),
//     no further frames after release.
//   With UART_TX_PARITY_EN: send 0x07 -> parity bit 1 before stop; send 0x03 -> parity bit 0; frame 2574 clks.

Source files
------------

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: memory-mapped UART transmitter.
// The CPU pushes bytes into a small FIFO and a serializer sends them as 8N1 frames.
// Build option: define UART_TX_PARITY_EN to send 8E1 frames instead.
//   8E1 frames carry an even parity bit between the data bits and the stop bit.
//   With the option, status bit 5 reads 1.
// Bus handshake: there is no valid/ready pair.
//   A write is taken on any clk edge where wen is high.
//   A read is combinational from address, and ren has no side effects.
// Register map:
//   addr 0 W : push data_in[7:0] when byte_select[0] is set.
//   addr 0 R : reads 0.
//   addr 1 R : {par, overflow, busy, full, empty, 0}.
//   addr 1 W : data_in[4]=1 clears overflow.
//   addr 2, addr 3 : read 0, writes are ignored.
module uart_tx_controller #(
  parameter int CLK_HZ        = 27000000,
  parameter int BAUD          = 115200,
  parameter int FIFO_DEPTH_LG = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ren,
  input  logic        wen,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  input  logic [3:0]  byte_select,
  output logic [31:0] data_out,
  output logic        uart_tx,
  output logic        irq_empty
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int DEPTH        = 1 << FIFO_DEPTH_LG;
  localparam logic [FIFO_DEPTH_LG:0] COUNT_FULL = (FIFO_DEPTH_LG + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic PARITY_PRESENT = 1'b1;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic PARITY_PRESENT = 1'b0;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]               mem [DEPTH];
  logic [FIFO_DEPTH_LG-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LG:0]   count;
  logic                     fifo_empty, fifo_full;
  logic                     push_req, push, pop, clr_ovf, overflow;

  // Serializer state
  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_n, busy, bit_end;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_n;
`endif

  // ren, the upper data lanes and the upper byte enables do not affect the block.
  logic unused_inputs;
  assign unused_inputs = ^{ren, data_in[31:8], byte_select[3:1]};

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == COUNT_FULL);
  assign push_req   = wen && (address == 2'd0) && byte_select[0];
  assign push       = push_req && !fifo_full;
  assign clr_ovf    = wen && (address == 2'd1) && data_in[4];
  assign busy       = (state != S_IDLE);
  assign bit_end    = (baud_cnt == CNT_LAST);

  // FIFO data array; no reset needed, the contents are only read when count != 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && fifo_full) overflow <= 1'b1;
      else if (clr_ovf)          overflow <= 1'b0;
    end
  end

  // Serializer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_n;
`endif
    end
  end

  // Serializer next-state logic.
  // This block also decides the FIFO pop and the line level for the next bit.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    pop        = 1'b0;
    tx_n       = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_n      = par_q;
`endif
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_n    = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
          par_n      = ^mem[rd_ptr];
`endif
          baud_cnt_n = '0;
          state_n    = S_START;
        end
      end
      S_START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = S_DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        tx_n = shift[0];
        if (bit_end) begin
          baud_cnt_n = '0;
          shift_n    = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_n = par_q;
        if (bit_end) begin
          baud_cnt_n = '0;
          state_n    = S_STOP;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          baud_cnt_n = '0;
          // Chain straight into the next frame so back-to-back bytes leave no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            par_n   = ^mem[rd_ptr];
`endif
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Line output is registered from the current state so it never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) uart_tx <= 1'b1;
    else        uart_tx <= tx_n;
  end

  // Registered interrupt: the FIFO is drained and the serializer is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_empty <= 1'b1;
    else        irq_empty <= fifo_empty && !busy;
  end

  // Combinational read mux.
  always_comb begin
    data_out = '0;
    if (address == 2'd1)
      data_out = {26'b0, PARITY_PRESENT, overflow, busy, fifo_full, fifo_empty, 1'b0};
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed testbench for uart_tx_controller.
// The bench has a clock/reset block and bus driver tasks.
// A frame monitor decodes uart_tx and checks each frame against an expected-byte queue.
// A final report prints the comparison counts.
`timescale 1ns/1ps
module tb_uart_tx_controller;

  localparam int CPB = 27000000 / 115200;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
  localparam logic [31:0] PAR_FLAG   = 32'h20;
`else
  localparam int          FRAME_BITS = 10;
  localparam logic [31:0] PAR_FLAG   = 32'h00;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [1:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  byte_select = '0;
  logic [31:0] data_out;
  logic        uart_tx;
  logic        irq_empty;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_frames = 0;
  bit         mon_en = 1'b1;
  logic [7:0] exp_q[$];
  longint     start_q[$];

  uart_tx_controller dut (
    .clk         (clk),
    .reset       (reset),
    .ren         (ren),
    .wen         (wen),
    .address     (address),
    .data_in     (data_in),
    .byte_select (byte_select),
    .data_out    (data_out),
    .uart_tx     (uart_tx),
    .irq_empty   (irq_empty)
  );

  // Clock block.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    address     = a;
    data_in     = d;
    byte_select = be;
    wen         = 1'b1;
    @(posedge clk);
    #1;
    wen         = 1'b0;
    byte_select = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    ren     = 1'b1;
    #1;
    d       = data_out;
    ren     = 1'b0;
  endtask

  // Queue a byte as expected on the line, then push it with junk in the upper lanes.
  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    bus_write(2'd0, {24'hC3A5E1, b}, 4'b0001);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    step(2);
    while (irq_empty !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check(tag, irq_empty, 1'b1);
  endtask

  // Scoreboard: decode each frame at mid-bit and compare it with the expected-byte queue.
  always begin : frame_mon
    logic [7:0] rx;
    logic [7:0] e;
    logic       s_bit, p_bit, t_bit;
    @(negedge uart_tx);
    if (mon_en) start_q.push_back($time / 10);
    repeat (CPB / 2) @(posedge clk);
    #1;
    s_bit = uart_tx;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1;
      rx[i] = uart_tx;
    end
    p_bit = 1'b0;
`ifdef UART_TX_PARITY_EN
    repeat (CPB) @(posedge clk);
    #1;
    p_bit = uart_tx;
`endif
    repeat (CPB) @(posedge clk);
    #1;
    t_bit = uart_tx;
    if (mon_en) begin
      n_frames++;
      check("start_bit", s_bit, 1'b0);
      check("stop_bit", t_bit, 1'b1);
      if (exp_q.size() == 0) begin
        check("frame_expected", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("frame_data", rx, e);
`ifdef UART_TX_PARITY_EN
        check("parity_bit", p_bit, ^e);
`else
        check("no_parity_slot", p_bit, 1'b0);
`endif
      end
    end
  end

  // Watchdog.
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin : main
    logic [31:0] rd;
    int lows;

    // Reset state.
    step(3);
    check("reset_tx", uart_tx, 1'b1);
    check("reset_irq", irq_empty, 1'b1);
    bus_read(2'd1, rd);
    check("reset_status", rd, 32'h02 | PAR_FLAG);
    bus_read(2'd0, rd);
    check("reset_addr0", rd, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(2);

    // Reserved registers.
    bus_write(2'd2, 32'hFFFF_FFFF, 4'b1111);
    bus_read(2'd2, rd);
    check("addr2_read", rd, 32'h0);
    bus_read(2'd3, rd);
    check("addr3_read", rd, 32'h0);
    bus_read(2'd1, rd);
    check("addr2_wr_ignored", rd, 32'h02 | PAR_FLAG);

    // Single byte 0x55: latency and irq timing.
    // The write lands on edge N, the pop on N+1, and the line falls after N+2.
    send_byte(8'h55);
    check("t1_tx_at_n", uart_tx, 1'b1);
    check("t1_irq_at_n", irq_empty, 1'b1);
    step(1);
    check("t1_tx_at_n1", uart_tx, 1'b1);
    check("t1_irq_at_n1", irq_empty, 1'b0);
    step(1);
    check("t1_tx_start_n2", uart_tx, 1'b0);
    step(FRAME_CLKS - 1);
    check("t1_irq_before_end", irq_empty, 1'b0);
    check("t1_tx_stop", uart_tx, 1'b1);
    step(1);
    check("t1_irq_after_end", irq_empty, 1'b1);

    // Three back-to-back bytes.
    start_q.delete();
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h43);
    bus_read(2'd1, rd);
    check("t2_status_busy", rd, 32'h08 | PAR_FLAG);
    wait_idle(4 * FRAME_CLKS, "t2_idle");
    step(10);
    check("t2_frame_count", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("t2_gap_01", 32'(start_q[1] - start_q[0]), FRAME_CLKS);
      check("t2_gap_12", 32'(start_q[2] - start_q[1]), FRAME_CLKS);
    end

    // Fill to full while the first frame blocks the line, then overflow.
    n_frames = 0;
    send_byte(8'h80);
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
    bus_read(2'd1, rd);
    check("t3_status_full", rd, 32'h0C | PAR_FLAG);
    bus_write(2'd0, 32'h0000_00EE, 4'b0001);
    bus_read(2'd1, rd);
    check("t3_status_ovf", rd, 32'h1C | PAR_FLAG);
    bus_read(2'd1, rd);
    check("t3_status_reread", rd, 32'h1C | PAR_FLAG);
    bus_write(2'd1, 32'h0000_0010, 4'b0001);
    bus_read(2'd1, rd);
    check("t3_ovf_cleared", rd, 32'h0C | PAR_FLAG);
    wait_idle(18 * FRAME_CLKS, "t3_idle");
    step(10);
    check("t3_frames", n_frames, 17);
    check("t3_queue_drained", exp_q.size(), 0);
    bus_read(2'd1, rd);
    check("t3_status_end", rd, 32'h02 | PAR_FLAG);

    // A write without byte lane 0 must not push.
    bus_write(2'd0, 32'h0000_0099, 4'b0010);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (uart_tx !== 1'b1) lows++;
    end
    check("t4_tx_idle", lows, 0);
    check("t4_irq", irq_empty, 1'b1);
    bus_read(2'd1, rd);
    check("t4_status", rd, 32'h02 | PAR_FLAG);

    // Asynchronous reset in the middle of data bit 3 of 0xA5.
    mon_en = 1'b0;
    bus_write(2'd0, 32'h0000_00A5, 4'b0001);
    step(1 + 4 * CPB + CPB / 2);
    check("t5_tx_bit3", uart_tx, 1'b0);
    reset = 1'b0;
    #1;
    check("t5_tx_async", uart_tx, 1'b1);
    check("t5_irq_async", irq_empty, 1'b1);
    bus_read(2'd1, rd);
    check("t5_status_reset", rd, 32'h02 | PAR_FLAG);
    @(negedge clk);
    reset = 1'b1;
    lows = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if (uart_tx !== 1'b1) lows++;
    end
    check("t5_no_frames", lows, 0);
    bus_read(2'd1, rd);
    check("t5_status_after", rd, 32'h02 | PAR_FLAG);
    check("final_queue_empty", exp_q.size(), 0);

    // Final report.
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
